// File: rtl/spi_seg_rx_pkg.sv
// Shared constants and types for the SPI segment receiver.
// Holds the command opcodes, the frame length and the FSM state encoding.
package spi_seg_pkg;

   localparam logic [7:0] CMD_WRITE_RAW = 8'h01;
   localparam logic [7:0] CMD_WRITE_HEX = 8'h02;
   localparam logic [7:0] CMD_BLANK     = 8'h03;

   localparam int         FRAME_BITS = 16;
   localparam logic [4:0] CNT_SAT    = 5'd17;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      DATA,
      WAIT_END,
      OVERRUN
   } state_e;

endpackage

// File: rtl/spi_seg_rx_if.sv
// SPI bus bundle between an external master and the segment receiver.
// The master drives clock, select and data; the slave returns readback.
interface spi_seg_rx_if;

   logic spi_sclk;
   logic spi_cs_n;
   logic spi_mosi;
   logic spi_miso;

   modport master (
      output spi_sclk,
      output spi_cs_n,
      output spi_mosi,
      input  spi_miso
   );

   modport slave (
      input  spi_sclk,
      input  spi_cs_n,
      input  spi_mosi,
      output spi_miso
   );

endinterface

// File: rtl/spi_seg_rx_hex.sv
// Hex nibble to 7-segment pattern (bit0=a .. bit6=g, active high).
// Purely combinational; shared with the display stage.
module seg_hex_decode (
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h00;
      unique case (nib_i)
         4'h0: seg_o = 7'h3F;
         4'h1: seg_o = 7'h06;
         4'h2: seg_o = 7'h5B;
         4'h3: seg_o = 7'h4F;
         4'h4: seg_o = 7'h66;
         4'h5: seg_o = 7'h6D;
         4'h6: seg_o = 7'h7D;
         4'h7: seg_o = 7'h07;
         4'h8: seg_o = 7'h7F;
         4'h9: seg_o = 7'h6F;
         4'hA: seg_o = 7'h77;
         4'hB: seg_o = 7'h7C;
         4'hC: seg_o = 7'h39;
         4'hD: seg_o = 7'h5E;
         4'hE: seg_o = 7'h79;
         4'hF: seg_o = 7'h71;
      endcase
   end

endmodule

// File: rtl/spi_seg_rx.sv
// SPI mode-0 slave that receives (cmd, data) frames and commits a
// segment pattern; the committed pattern is read back on MISO.
module spi_seg_rx
   import spi_seg_pkg::*;
#(
   parameter int         SYNC_STAGES   = 2,
   parameter logic [7:0] RESET_PATTERN = 8'h00
) (
   input  logic         clk,
   input  logic         rst_n,
   spi_seg_rx_if.slave  spi,
   output logic [7:0]   seg_out,
   output logic         seg_valid,
   output logic         frame_err
);

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   cs_prev_q;

   state_e     state_q;
   logic [4:0] cnt_q;
   logic [6:0] sh_q;
   logic [7:0] cmd_q;
   logic [7:0] data_q;
   logic [6:0] miso_sh_q;
   logic       miso_q;
   logic [7:0] seg_q;
   logic       valid_q;
   logic       err_q;

   logic       sclk_s;
   logic       cs_s;
   logic       mosi_s;
   logic       sclk_rise;
   logic       sclk_fall;
   logic       cs_rise;
   logic       cs_fall;
   logic [7:0] sh_d;
   logic [6:0] hex_seg;
   logic       cmd_ok_d;
   logic [7:0] pat_d;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign sh_d      = {sh_q, mosi_s};

   assign spi.spi_miso = miso_q;
   assign seg_out      = seg_q;
   assign seg_valid    = valid_q;
   assign frame_err    = err_q;

   seg_hex_decode u_hex (
      .nib_i (data_q[3:0]),
      .seg_o (hex_seg)
   );

   always_comb begin
      cmd_ok_d = 1'b0;
      pat_d    = seg_q;
      unique case (cmd_q)
         CMD_WRITE_RAW: begin
            cmd_ok_d = 1'b1;
            pat_d    = data_q;
         end
         CMD_WRITE_HEX: begin
            cmd_ok_d = 1'b1;
            pat_d    = {data_q[7], hex_seg};
         end
         CMD_BLANK: begin
            cmd_ok_d = 1'b1;
            pat_d    = 8'h00;
         end
         default: ;
      endcase
   end

   // Synchronizers preset to the bus idle levels so reset release is quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q, spi.spi_sclk};
         cs_sync_q   <= {cs_sync_q, spi.spi_cs_n};
         mosi_sync_q <= {mosi_sync_q, spi.spi_mosi};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         cmd_q     <= '0;
         data_q    <= '0;
         miso_sh_q <= '0;
         miso_q    <= 1'b0;
         seg_q     <= RESET_PATTERN;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         // A cs_n rise ends the frame and masks any coincident sclk edge.
         if (cs_rise) begin
            if (state_q == WAIT_END && cmd_ok_d) begin
               seg_q   <= pat_d;
               valid_q <= 1'b1;
            end else if (state_q != IDLE) begin
               err_q <= 1'b1;
            end
            state_q <= IDLE;
            miso_q  <= 1'b0;
         end else if (state_q == IDLE) begin
            if (cs_fall) begin
               state_q   <= CMD;
               cnt_q     <= '0;
               miso_sh_q <= seg_q[6:0];
               miso_q    <= seg_q[7];
            end
         end else if (sclk_rise && !cs_s) begin
            sh_q  <= sh_d[6:0];
            cnt_q <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 5'd1;
            if (state_q == CMD && cnt_q == 5'd7) begin
               cmd_q   <= sh_d;
               state_q <= DATA;
               miso_q  <= 1'b0;
            end else if (state_q == DATA &&
                         cnt_q == 5'(FRAME_BITS - 1)) begin
               data_q  <= sh_d;
               state_q <= WAIT_END;
            end else if (state_q == WAIT_END) begin
               state_q <= OVERRUN;
            end
         end else if (sclk_fall && state_q == CMD) begin
            miso_sh_q <= {miso_sh_q[5:0], 1'b0};
            miso_q    <= miso_sh_q[6];
         end
      end
   end

endmodule

// File: tb/tb_spi_seg_rx.sv
// Directed bench for spi_seg_rx: drives SPI frames with 4-clk sclk
// half-periods and checks commits, rejects, readback and latency.
module tb_spi_seg_rx;

   logic       clk;
   logic       rst_n;
   logic [7:0] seg_out;
   logic       seg_valid;
   logic       frame_err;

   int errors = 0;
   int checks = 0;
   int nvalid = 0;
   int nerr   = 0;
   int nboth  = 0;
   logic [7:0] vlog[$];

   spi_seg_rx_if spi_if ();

   spi_seg_rx #(
      .SYNC_STAGES   (2),
      .RESET_PATTERN (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (spi_if.slave),
      .seg_out   (seg_out),
      .seg_valid (seg_valid),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (seg_valid) begin
         nvalid++;
         vlog.push_back(seg_out);
      end
      if (frame_err) nerr++;
      if (seg_valid && frame_err) nboth++;
   end

   task automatic spi_frame(input logic [31:0] bits, input int n,
                            input bit raise_cs,
                            output logic [15:0] miso_w);
      miso_w = '0;
      @(posedge clk); #1;
      spi_if.spi_cs_n = 1'b0;
      repeat (4) @(posedge clk);
      for (int i = 0; i < n; i++) begin
         #1;
         spi_if.spi_mosi = bits[n-1-i];
         miso_w = {miso_w[14:0], spi_if.spi_miso};
         spi_if.spi_sclk = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         spi_if.spi_sclk = 1'b0;
         repeat (4) @(posedge clk);
      end
      #1;
      if (raise_cs) spi_if.spi_cs_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      spi_if.spi_cs_n = 1'b1;
      spi_if.spi_sclk = 1'b0;
      spi_if.spi_mosi = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (seg_out !== 8'h00 || seg_valid !== 1'b0 ||
          frame_err !== 1'b0 || spi_if.spi_miso !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: seg=%h v=%b e=%b miso=%b want 00/0/0/0",
                  seg_out, seg_valid, frame_err, spi_if.spi_miso);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      checks++;
      if (seg_out !== 8'h00 || spi_if.spi_miso !== 1'b0) begin
         errors++;
         $display("FAIL idle_outputs: seg=%h miso=%b want 00/0",
                  seg_out, spi_if.spi_miso);
      end
      checks++;
      if (nvalid !== 0 || nerr !== 0) begin
         errors++;
         $display("FAIL idle_pulses: valid=%0d err=%0d want 0/0",
                  nvalid, nerr);
      end
   endtask

   task automatic test_write_raw;
      logic [15:0] m;
      int v0 = nvalid;
      int e0 = nerr;
      spi_frame(32'h01A5, 16, 1'b1, m);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (seg_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: seg_valid=%b want 0", seg_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (seg_valid !== 1'b1 || seg_out !== 8'hA5) begin
         errors++;
         $display("FAIL latency_edge: v=%b seg=%h want 1/a5",
                  seg_valid, seg_out);
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (seg_out !== 8'hA5) begin
         errors++;
         $display("FAIL raw_seg: got %h want a5", seg_out);
      end
      checks++;
      if (nvalid - v0 !== 1 || nerr - e0 !== 0) begin
         errors++;
         $display("FAIL raw_pulses: valid=%0d err=%0d want 1/0",
                  nvalid - v0, nerr - e0);
      end
   endtask

   task automatic test_hex_blank_miso;
      logic [15:0] m;
      int v0 = nvalid;
      spi_frame(32'h028B, 16, 1'b1, m);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (seg_out !== 8'hFC) begin
         errors++;
         $display("FAIL hex_seg: got %h want fc", seg_out);
      end
      spi_frame(32'h03C7, 16, 1'b1, m);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (m[15:8] !== 8'hFC) begin
         errors++;
         $display("FAIL miso_cmd: got %h want fc", m[15:8]);
      end
      checks++;
      if (m[7:0] !== 8'h00) begin
         errors++;
         $display("FAIL miso_data: got %h want 00", m[7:0]);
      end
      checks++;
      if (seg_out !== 8'h00 || nvalid - v0 !== 2) begin
         errors++;
         $display("FAIL blank: seg=%h valid=%0d want 00/2",
                  seg_out, nvalid - v0);
      end
   endtask

   task automatic test_errors;
      logic [15:0] m;
      int v0 = nvalid;
      int e0 = nerr;
      spi_frame(32'h0711, 16, 1'b1, m);
      repeat (10) @(posedge clk);
      spi_frame(32'h0123, 12, 1'b1, m);
      repeat (10) @(posedge clk);
      spi_frame(32'h00203, 17, 1'b1, m);
      repeat (10) @(posedge clk);
      spi_frame(32'h0, 0, 1'b1, m);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (nerr - e0 !== 4) begin
         errors++;
         $display("FAIL err_count: got %0d want 4", nerr - e0);
      end
      checks++;
      if (nvalid - v0 !== 0 || seg_out !== 8'h00) begin
         errors++;
         $display("FAIL err_side: valid=%0d seg=%h want 0/00",
                  nvalid - v0, seg_out);
      end
   endtask

   task automatic test_midframe_reset;
      logic [15:0] m;
      int v0;
      int e0;
      spi_frame(32'h013C >> 6, 10, 1'b0, m);
      @(posedge clk); #1;
      rst_n = 1'b0;
      spi_if.spi_cs_n = 1'b1;
      spi_if.spi_sclk = 1'b0;
      @(negedge clk);
      checks++;
      if (seg_out !== 8'h00 || spi_if.spi_miso !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: seg=%h miso=%b want 00/0",
                  seg_out, spi_if.spi_miso);
      end
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      v0 = nvalid;
      e0 = nerr;
      spi_frame(32'h0166, 16, 1'b1, m);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (seg_out !== 8'h66) begin
         errors++;
         $display("FAIL rst_seg: got %h want 66", seg_out);
      end
      checks++;
      if (nvalid - v0 !== 1 || nerr - e0 !== 0) begin
         errors++;
         $display("FAIL rst_pulses: valid=%0d err=%0d want 1/0",
                  nvalid - v0, nerr - e0);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] m;
      vlog.delete();
      spi_frame(32'h0200, 16, 1'b1, m);
      repeat (2) @(posedge clk);
      spi_frame(32'h020F, 16, 1'b1, m);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (vlog.size() !== 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 2", vlog.size());
      end else begin
         checks++;
         if (vlog[0] !== 8'h3F || vlog[1] !== 8'h71) begin
            errors++;
            $display("FAIL b2b_seg: got %h,%h want 3f,71",
                     vlog[0], vlog[1]);
         end
      end
      checks++;
      if (seg_out !== 8'h71) begin
         errors++;
         $display("FAIL b2b_final: got %h want 71", seg_out);
      end
   endtask

   initial begin
      test_reset();
      test_write_raw();
      test_hex_blank_miso();
      test_errors();
      test_midframe_reset();
      test_back_to_back();
      checks++;
      if (nboth !== 0) begin
         errors++;
         $display("FAIL excl_pulses: both high %0d times want 0", nboth);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
